// File: rtl/issue_arbiter_pkg.sv
// ============================================================================
// Module      : issue_arbiter_pkg
// Description : Shared scheduler types and constants for the issue arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package issue_arbiter_pkg;

   localparam int REQ_NUM_DEFAULT  = 2;
   localparam int ISSUE_BASE_W     = 56;
   localparam int ISSUE_OPT_W      = 8;
   localparam int ISSUE_PAYLOAD_W  = ISSUE_BASE_W + ISSUE_OPT_W;

   typedef struct packed {
      logic [ISSUE_BASE_W-1:0] base;
      logic [ISSUE_OPT_W-1:0]  opt;
   } issue_payload_t;

   // Index width for n requesters; a single requester still needs one bit.
   function automatic int src_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

`default_nettype wire

// File: rtl/issue_arbiter_rr_priority_picker.sv
// ============================================================================
// Module      : rr_priority_picker
// Description : Combinational search for the first set request at or above
//               the pointer, wrapping around; one-hot grant plus index.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_priority_picker
   import issue_arbiter_pkg::*;
#(
   parameter int N     = REQ_NUM_DEFAULT,
   parameter int IDX_W = src_width(N)
) (
   input  logic [N-1:0]     req_i,
   input  logic [IDX_W-1:0] ptr_i,
   output logic [N-1:0]     gnt_o,
   output logic [IDX_W-1:0] idx_o,
   output logic             any_o
);

   int pos;

   always_comb begin
      gnt_o = '0;
      idx_o = '0;
      any_o = 1'b0;
      pos   = 0;
      for (int off = 0; off < N; off++) begin
         pos = int'(ptr_i) + off;
         if (pos >= N) begin
            pos = pos - N;
         end
         if (!any_o && req_i[pos]) begin
            any_o      = 1'b1;
            gnt_o[pos] = 1'b1;
            idx_o      = IDX_W'(pos);
         end
      end
   end

endmodule

`default_nettype wire

// File: rtl/issue_arbiter.sv
// ============================================================================
// Module      : issue_arbiter
// Description : Arbitrates reservation-station issue ports into a one-entry
//               issue register feeding a single functional unit.
//               ISSUE_ARB_ROUND_ROBIN_EN selects round-robin over fixed priority.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module issue_arbiter
   import issue_arbiter_pkg::*;
#(
   parameter  int REQ_NUM    = REQ_NUM_DEFAULT,
   parameter  int DATA_WIDTH = ISSUE_PAYLOAD_W,
   localparam int SRC_W      = src_width(REQ_NUM)
) (
   input  logic                                clk,
   input  logic                                rst_n,
   input  logic                                flush_i,
   input  logic [REQ_NUM-1:0]                  req_valid_i,
   input  logic [REQ_NUM-1:0][DATA_WIDTH-1:0]  req_data_i,
   output logic [REQ_NUM-1:0]                  req_ready_o,
   input  logic                                fu_ready_i,
   output logic                                issue_valid_o,
   output logic [DATA_WIDTH-1:0]               issue_data_o,
   output logic [SRC_W-1:0]                    issue_src_o
);

   logic                  valid_q, valid_d;
   logic [DATA_WIDTH-1:0] data_q,  data_d;
   logic [SRC_W-1:0]      src_q,   src_d;
   logic [SRC_W-1:0]      ptr;

   logic                  drain;
   logic                  slot_free;
   logic                  grant_any;
   logic [REQ_NUM-1:0]    pick_gnt;
   logic [SRC_W-1:0]      pick_idx;
   logic                  pick_any;

   rr_priority_picker #(
      .N     (REQ_NUM),
      .IDX_W (SRC_W)
   ) u_picker (
      .req_i (req_valid_i),
      .ptr_i (ptr),
      .gnt_o (pick_gnt),
      .idx_o (pick_idx),
      .any_o (pick_any)
   );

   assign issue_valid_o = valid_q & ~flush_i;
   assign issue_data_o  = data_q;
   assign issue_src_o   = src_q;
   assign drain         = issue_valid_o & fu_ready_i;
   assign slot_free     = ~valid_q | drain;
   assign grant_any     = slot_free & ~flush_i & pick_any;
   assign req_ready_o   = grant_any ? pick_gnt : '0;

   always_comb begin
      valid_d = valid_q;
      data_d  = data_q;
      src_d   = src_q;
      if (flush_i) begin
         valid_d = 1'b0;
      end else if (grant_any) begin
         valid_d = 1'b1;
         data_d  = req_data_i[pick_idx];
         src_d   = pick_idx;
      end else if (drain) begin
         valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         valid_q <= 1'b0;
         data_q  <= '0;
         src_q   <= '0;
      end else begin
         valid_q <= valid_d;
         data_q  <= data_d;
         src_q   <= src_d;
      end
   end

`ifdef ISSUE_ARB_ROUND_ROBIN_EN
   logic [SRC_W-1:0] ptr_q, ptr_d;

   // Pointer moves just past the winner so it gets lowest priority next time.
   always_comb begin
      ptr_d = ptr_q;
      if (flush_i) begin
         ptr_d = '0;
      end else if (grant_any) begin
         ptr_d = (pick_idx == SRC_W'(REQ_NUM - 1)) ? '0 : pick_idx + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         ptr_q <= '0;
      end else begin
         ptr_q <= ptr_d;
      end
   end

   assign ptr = ptr_q;
`else
   assign ptr = '0;
`endif

endmodule

`default_nettype wire
